// File: rtl/mult8_seq_ctrl_if.sv
// rtl/mult8_seq_ctrl_if.sv - operand/handshake/adder bundle for the sequential 8x8 multiplier
// The master side loads operands and supplies the external adder; the slave side is the controller.
interface mult8_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [WIDTH-1:0]     add_a;
   logic [WIDTH-1:0]     add_b;
   logic [WIDTH-1:0]     add_s;
   logic                 add_co;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;
   logic                 done;

   modport master (
      output start, a, b, add_s, add_co,
      input  add_a, add_b, p, busy, done
   );

   modport slave (
      input  start, a, b, add_s, add_co,
      output add_a, add_b, p, busy, done
   );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - shift-and-add multiply sequencer driving one shared external adder
// Eight RUN iterations fold the adder result into {hi,lo}; p is written only on completion.
module mult8_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mult8_seq_ctrl_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   p_q;
   logic                 busy_q;
   logic                 done_q;

   // The adder operands come straight from registers so the adder path starts at a flop.
   assign bus.add_a = hi;
   assign bus.add_b = lo[0] ? mcand : '0;
   assign bus.p     = p_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         p_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  mcand  <= bus.a;
                  lo     <= bus.b;
                  hi     <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               // Carry-out lands in hi's MSB, so the 16-bit partial product never overflows.
               hi  <= {bus.add_co, bus.add_s[WIDTH-1:1]};
               lo  <= {bus.add_s[0], lo[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  p_q    <= {bus.add_co, bus.add_s[WIDTH-1:1], bus.add_s[0], lo[WIDTH-1:1]};
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/mult8_seq_ctrl.md
# mult8_seq_ctrl

Sequencing controller that reuses one external 8-bit ripple adder (sum + carry-out, carry-in tied 0) to perform an unsigned 8x8 -> 16-bit shift-and-add multiply over eight iterations. It sits between the board-level operand registers (switch-loaded A/B) and the shared adder instance. It owns the accumulator, multiplier shift register, iteration counter and start/done handshake. The adder stays purely combinational outside this block.

## Interface
Parameters:
- WIDTH, 8, operand width; only 8 is supported and verified.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  8  multiplicand, captured on accept.
- B  input  8  multiplier, captured on accept.
- AddA  output  8  adder operand 0 = accumulator high byte Hi.
- AddB  output  8  adder operand 1 = Mcand when Lo[0]=1, else 8'h00.
- AddS  input  8  adder sum (AddA+AddB)[7:0].
- AddCo  input  1  adder carry-out.
- P  output  16  product register.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle completion pulse.

## Operation
- Internal registers: Mcand[7:0], Hi[7:0], Lo[7:0], Cnt[2:0], state, P[15:0].
- States: IDLE, RUN, DONE.
  - IDLE: if Start=1, load Mcand<=A, Lo<=B, Hi<=0, Cnt<=0, go RUN. Otherwise hold.
  - RUN: each edge performs one iteration:
    - Hi <= {AddCo, AddS[7:1]}
    - Lo <= {AddS[0], Lo[7:1]}
    - Cnt <= Cnt+1
    - When Lo[0]=0, AddB=0, so this reduces to a plain right shift of {0,Hi,Lo}.
    - On the edge with Cnt==7: also load P <= {AddCo, AddS[7:1], AddS[0], Lo[7:1]}, i.e. the post-shift {Hi,Lo}, and go DONE.
  - DONE: Done=1 for this cycle; unconditionally return to IDLE. Start is ignored in DONE.
- Start is ignored in RUN and DONE. A and B are don't-care after the accept edge.
- P holds its value until the next completion; it does not change on accept.
- Arithmetic: unsigned only. The result is exact, 255*255 = 16'hFE01 max, so no overflow flag. The carry is absorbed into Hi[7] every iteration.
- AddA/AddB are combinational from registers and valid in every state. Outside RUN, their values and the returned AddS/AddCo are ignored.

## Timing
- Reset (Resetn=0, asynchronous): state=IDLE, Busy=0, Done=0, P=16'h0000, Hi=Lo=Mcand=0, Cnt=0.
- Reset release is synchronous to the next Clock edge; no edge is consumed.
- Latency, counting the accepting edge as edge 0:
  - Edges 1..8 are the RUN iterations; Busy=1 after edge 0 through edge 8.
  - P is valid and Done=1 after edge 8.
  - Done=0 and IDLE after edge 9.
  - A new Start is accepted at edge 10 at the earliest. With Start held high, the throughput is one product per 10 cycles.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. A partial product is never written to P and no Done pulse is produced.
- The adder path (AddA/AddB -> AddS/AddCo -> Hi/Lo) must settle within one Clock period. It is the critical path.

## Test plan
- Reset, then A=8'd13, B=8'd11, Start pulse -> Busy high for 8 cycles; Done pulse after edge 8; P=16'h008F; P holds after Done drops.
- A=8'hFF, B=8'hFF -> P=16'hFE01. Checks that AddCo propagates into Hi every iteration.
- A=8'h00, B=8'hA5, then A=8'hA5, B=8'h00 -> P=16'h0000 both times. A=8'h01, B=8'h80 -> P=16'h0080.
- Start held high, operand pairs changed after each accept edge -> accepts at edges 0, 10, 20 with correct P each time. Operand changes during RUN do not disturb the result.
- Start re-pulsed mid-RUN and in DONE -> ignored; Cnt sequence and P unaffected.
- Resetn pulsed low at iteration 4 of 9*9 -> Busy=0, Done=0, P=16'h0000 immediately, no Done pulse. A subsequent 9*9 gives P=16'h0051.
